// File: rtl/product_accumulator.sv
// product_accumulator: sums a frame of `len` signed products arriving on a
// valid/ready stream and presents the frame sum on a valid/ready output.
// Optional feature macro ACC_SAT_EN: when defined, each add saturates to the
// ACC_W signed range and a sticky ovf flag records any clamp in the frame.
// When undefined, the accumulator wraps modulo 2^ACC_W and ovf is tied 0.
module product_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [LEN_W-1:0]         len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     busy,
  output logic                     ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [LEN_W-1:0]         rem_q, rem_d;
  logic                     accept;

`ifdef ACC_SAT_EN
  logic                     ovf_q, ovf_d;
  logic signed [ACC_W:0]    sum_wide;

  // One guard bit above the accumulator so a single add can never lose its sign.
  function automatic logic signed [ACC_W:0] wide_add(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [PROD_W-1:0] p
  );
    return (ACC_W+1)'(a) + (ACC_W+1)'(p);
  endfunction

  // Overflow shows as the guard bit disagreeing with the accumulator sign bit.
  function automatic logic add_overflowed(input logic signed [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  // Clamp toward the side given by the true (guard-bit) sign.
  function automatic logic signed [ACC_W-1:0] saturate(input logic signed [ACC_W:0] s);
    if (!add_overflowed(s))
      return s[ACC_W-1:0];
    else if (s[ACC_W])
      return {1'b1, {(ACC_W-1){1'b0}}};
    else
      return {1'b0, {(ACC_W-1){1'b1}}};
  endfunction

  assign sum_wide = wide_add(acc_q, in_product);
  assign ovf      = ovf_q;
`else
  assign ovf      = 1'b0;
`endif

  // Control decodes from registered state only; no path from in_valid/out_ready.
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign accept    = in_valid && (state_q == ACCUM);

  // Next-state, accumulator and remaining-count logic.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
`ifdef ACC_SAT_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
`ifdef ACC_SAT_EN
          ovf_d = 1'b0;
`endif
          if (len == '0) begin
            state_d = DONE;
          end else begin
            rem_d   = len;
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (accept) begin
`ifdef ACC_SAT_EN
          acc_d = saturate(sum_wide);
          if (add_overflowed(sum_wide))
            ovf_d = 1'b1;
`else
          acc_d = acc_q + ACC_W'(in_product);
`endif
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
`ifdef ACC_SAT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
`ifdef ACC_SAT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Testbench for product_accumulator (ACC_W=34): directed table, hand-written
// handshake/reset sequences, and random frames against a frame-sum model.
module tb_product_accumulator;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 34;
  localparam int LEN_W  = 8;
`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam longint ACC_MAX = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< (ACC_W-1));

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [LEN_W-1:0]         len = '0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [PROD_W-1:0] in_product = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     busy;
  logic                     ovf;

  int checks = 0;
  int failures = 0;

  product_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                len;
    logic [4:0][31:0]  prods;
    longint            exp_sum;
    bit                exp_ovf;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Frame sum from the arithmetic rules: exact sum, then wrap or clamp per add.
  function automatic longint model_sum(input longint p[$], output bit ov);
    longint s = 0;
    ov = 1'b0;
    foreach (p[i]) begin
      s = s + p[i];
      if (SAT) begin
        if (s > ACC_MAX) begin s = ACC_MAX; ov = 1'b1; end
        if (s < ACC_MIN) begin s = ACC_MIN; ov = 1'b1; end
      end else begin
        s = (s <<< (64-ACC_W)) >>> (64-ACC_W);
      end
    end
    return s;
  endfunction

  task automatic run_frame(input string nm, input int n, input longint p[$],
                           input int gap_pct, input int hold,
                           input longint exp_sum, input bit exp_ovf);
    int idx = 0;
    int cyc = 0;
    bit take;
    start = 1'b1;
    len   = LEN_W'(n);
    tick();
    start = 1'b0;
    len   = '0;
    if (n != 0) begin
      chk({nm, "_busy_accum"}, longint'(busy), 1);
      while (idx < n && cyc < n*20 + 50) begin
        in_valid   = ($urandom_range(99) >= gap_pct);
        in_product = PROD_W'(p[idx]);
        take = in_valid && in_ready;
        chk({nm, "_in_ready"}, longint'(in_ready), 1);
        chk({nm, "_out_valid_accum"}, longint'(out_valid), 0);
        tick();
        if (take) idx++;
        cyc++;
      end
      in_valid = 1'b0;
      if (idx < n) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout accepted=%0d required=%0d", nm, idx, n);
      end
    end
    chk({nm, "_out_valid"}, longint'(out_valid), 1);
    chk({nm, "_in_ready_done"}, longint'(in_ready), 0);
    chk({nm, "_busy_done"}, longint'(busy), 1);
    chk({nm, "_sum"}, longint'(out_sum), exp_sum);
    chk({nm, "_ovf"}, longint'(ovf), longint'(exp_ovf));
    repeat (hold) begin
      out_ready = 1'b0;
      tick();
      chk({nm, "_hold_valid"}, longint'(out_valid), 1);
      chk({nm, "_hold_sum"}, longint'(out_sum), exp_sum);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_idle_valid"}, longint'(out_valid), 0);
    chk({nm, "_idle_busy"}, longint'(busy), 0);
    chk({nm, "_idle_sum"}, longint'(out_sum), exp_sum);
  endtask

  initial begin
    longint q[$];
    longint s;
    bit     ov;
    int     pat[6];
    longint pv[6];

    // Directed table: plan items 1, 3, 4, 5 (sat and wrap expectations).
    tbl[0].len = 4; tbl[0].prods = '0;
    tbl[0].prods[0] = 32'd100; tbl[0].prods[1] = 32'hFFFF_FFCE;
    tbl[0].prods[2] = 32'd7;   tbl[0].prods[3] = 32'hFFFF_FFFD;
    tbl[0].exp_sum = 54; tbl[0].exp_ovf = 1'b0;
    tbl[1].len = 0; tbl[1].prods = '0;
    tbl[1].exp_sum = 0; tbl[1].exp_ovf = 1'b0;
    tbl[2].len = 5; tbl[2].prods = {5{32'h7FFF_FFFF}};
    tbl[2].exp_sum = SAT ? 64'sd8589934591 : -64'sd6442450949;
    tbl[2].exp_ovf = SAT;
    tbl[3].len = 5; tbl[3].prods = {5{32'h8000_0000}};
    tbl[3].exp_sum = SAT ? -64'sd8589934592 : 64'sd6442450944;
    tbl[3].exp_ovf = SAT;
    tbl[4].len = 1; tbl[4].prods = '0; tbl[4].prods[0] = 32'd1;
    tbl[4].exp_sum = 1; tbl[4].exp_ovf = 1'b0;

    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_sum", longint'(out_sum), 0);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      q.delete();
      for (int i = 0; i < tbl[k].len; i++)
        q.push_back(longint'($signed(tbl[k].prods[i])));
      run_frame($sformatf("tbl%0d", k), tbl[k].len, q, 0, 0,
                tbl[k].exp_sum, tbl[k].exp_ovf);
    end

    // Gapped input, stalled output, start ignored in DONE.
    pat = '{1, 0, 0, 1, 0, 1};
    pv  = '{10, 0, 0, 20, 0, 30};
    start = 1'b1; len = 8'd3; tick(); start = 1'b0; len = '0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i][0];
      in_product = PROD_W'(pv[i]);
      chk("gap_in_ready", longint'(in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = (i == 2) ? 8'd7 : 8'd0;
      chk("gap_valid", longint'(out_valid), 1);
      chk("gap_sum", longint'(out_sum), 60);
      chk("gap_in_ready_done", longint'(in_ready), 0);
      tick();
    end
    start = 1'b0; len = '0;
    chk("gap_sum_after_start", longint'(out_sum), 60);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("gap_idle_valid", longint'(out_valid), 0);
    chk("gap_idle_busy", longint'(busy), 0);
    tick();
    chk("gap_start_not_queued", longint'(busy), 0);

    // Reset mid-frame after 2 of 4 products.
    start = 1'b1; len = 8'd4; tick(); start = 1'b0; len = '0;
    in_valid = 1'b1; in_product = 32'sd1000; tick();
    in_product = 32'sd2000; tick();
    in_valid = 1'b0; rst_n = 1'b0; tick();
    chk("mid_rst_in_ready", longint'(in_ready), 0);
    chk("mid_rst_valid", longint'(out_valid), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_ovf", longint'(ovf), 0);
    chk("mid_rst_sum", longint'(out_sum), 0);
    rst_n = 1'b1; tick();
    q.delete(); q.push_back(5); q.push_back(6);
    run_frame("post_rst", 2, q, 0, 0, 11, 1'b0);

    // Random frames against the model.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = $urandom_range(12);
      q.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(3))
          0: q.push_back(64'sd2147483647);
          1: q.push_back(-64'sd2147483648);
          default: q.push_back(longint'(int'($urandom())));
        endcase
      end
      s = model_sum(q, ov);
      run_frame($sformatf("rnd%0d", f), n, q, 30, $urandom_range(3), s, ov);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
